// File: rtl/led_blink_array.sv
// Multi-channel LED blinker: each channel pulses for one cycle at either a fixed
// programmable interval or a pseudo-random interval taken from a shared LFSR.
module led_blink_array #(
  parameter int                       NUM_CH        = 3,
  parameter int                       CNT_W         = 8,
  parameter logic [NUM_CH*CNT_W-1:0]  RST_INTERVALS = {8'd0, 8'd5, 8'd10},
  parameter logic [NUM_CH-1:0]        RST_MODES     = 3'b100,
  parameter logic [15:0]              LFSR_SEED     = 16'hACE1,
  parameter int                       RAND_BITS     = 4,
  parameter int                       RAND_MIN      = 4,
  localparam int                      CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_edge,
  input  logic              rstbtn,
  input  logic              en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_mode,
  input  logic [CNT_W-1:0]  cfg_interval,
  output logic [NUM_CH-1:0] led,
  output logic              any_pulse
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_RAND = CNT_W'(RAND_MIN) + CNT_W'(LFSR_SEED[RAND_BITS-1:0]);

  logic [15:0]                   lfsr, lfsr_n;
  logic [NUM_CH-1:0]             mode, mode_n;
  logic [NUM_CH-1:0][CNT_W-1:0]  iv, iv_n;
  logic [NUM_CH-1:0][CNT_W-1:0]  cur_iv, cur_iv_n;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt, cnt_n;
  logic [NUM_CH-1:0]             led_n;
  logic [CNT_W-1:0]              rand_iv;

  // Random intervals always come from the LFSR value before this edge's shift
  assign rand_iv = CNT_W'(RAND_MIN) + CNT_W'(lfsr[RAND_BITS-1:0]);

  always_comb begin
    lfsr_n   = lfsr;
    mode_n   = mode;
    iv_n     = iv;
    cur_iv_n = cur_iv;
    cnt_n    = cnt;
    led_n    = '0;
    if (en) begin
      lfsr_n = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (int'(cfg_ch) == i)) begin
        mode_n[i]   = cfg_mode;
        iv_n[i]     = cfg_interval;
        cnt_n[i]    = '0;
        cur_iv_n[i] = cfg_mode ? rand_iv : cfg_interval;
      end else if (en) begin
        if (cur_iv[i] == '0) begin
          cnt_n[i] = '0;
        end else if (cnt[i] == cur_iv[i] - ONE) begin
          led_n[i]    = 1'b1;
          cnt_n[i]    = '0;
          cur_iv_n[i] = mode[i] ? rand_iv : iv[i];
        end else begin
          cnt_n[i] = cnt[i] + ONE;
        end
      end
    end
  end

  // any_pulse is taken from the next-state vector so it lines up with led
  always_ff @(posedge clk_edge or posedge rstbtn) begin
    if (rstbtn) begin
      lfsr      <= LFSR_SEED;
      mode      <= RST_MODES;
      iv        <= RST_INTERVALS;
      cnt       <= '0;
      led       <= '0;
      any_pulse <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cur_iv[i] <= RST_MODES[i] ? RST_RAND : RST_INTERVALS[i*CNT_W +: CNT_W];
      end
    end else begin
      lfsr      <= lfsr_n;
      mode      <= mode_n;
      iv        <= iv_n;
      cur_iv    <= cur_iv_n;
      cnt       <= cnt_n;
      led       <= led_n;
      any_pulse <= |led_n;
    end
  end

endmodule

// File: tb/tb_led_blink_array.sv
// Randomised scoreboard bench for led_blink_array: a countdown model predicts each
// cycle's led vector, a monitor process pops and compares after every rising edge.
module tb_led_blink_array;

  logic       clk_edge;
  logic       rstbtn;
  logic       en;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic       cfg_mode;
  logic [7:0] cfg_interval;
  logic [2:0] led;
  logic       any_pulse;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] exp_q[$];

  // Model state: cycles remaining until the next pulse and the current period
  int          per_m[3];
  int          rem_m[3];
  bit          mode_m[3];
  logic [15:0] lfsr_m;

  led_blink_array dut (
    .clk_edge    (clk_edge),
    .rstbtn      (rstbtn),
    .en          (en),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_mode    (cfg_mode),
    .cfg_interval(cfg_interval),
    .led         (led),
    .any_pulse   (any_pulse)
  );

  initial clk_edge = 1'b0;
  always #5 clk_edge = ~clk_edge;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  task automatic model_reset();
    int rst_iv[3] = '{10, 5, 0};
    lfsr_m = 16'hACE1;
    for (int i = 0; i < 3; i++) begin
      mode_m[i] = (i == 2);
      per_m[i]  = mode_m[i] ? 4 + int'(lfsr_m[3:0]) : rst_iv[i];
      rem_m[i]  = per_m[i];
    end
  endtask

  // Drive one cycle of inputs, predict the led vector after the next edge
  task automatic applyStimulus(input bit e, input bit we, input logic [1:0] ch,
                               input bit md, input logic [7:0] ivl);
    logic [2:0] exp_led;
    int         rnd;
    en = e; cfg_we = we; cfg_ch = ch; cfg_mode = md; cfg_interval = ivl;
    exp_led = '0;
    rnd = 4 + int'(lfsr_m[3:0]);
    for (int i = 0; i < 3; i++) begin
      if (we && int'(ch) == i) begin
        mode_m[i] = md;
        per_m[i]  = md ? rnd : int'(ivl);
        rem_m[i]  = per_m[i];
      end else if (e && per_m[i] != 0) begin
        if (rem_m[i] == 1) begin
          exp_led[i] = 1'b1;
          if (mode_m[i]) per_m[i] = rnd;
          rem_m[i] = per_m[i];
        end else begin
          rem_m[i]--;
        end
      end
    end
    if (e) lfsr_m = lfsr_next(lfsr_m);
    exp_q.push_back({|exp_led, exp_led});
    @(negedge clk_edge);
  endtask

  task automatic reset_dut();
    rstbtn = 1'b1;
    en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = 1'b0; cfg_interval = '0;
    #2;
    model_reset();
    rstbtn = 1'b0;
  endtask

  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(posedge clk_edge);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("led", 32'(led), 32'(e[2:0]));
        checkOutput("any_pulse", 32'(any_pulse), 32'(e[3]));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int pulses;
    int gap;
    int cyc;
    rstbtn = 1'b1;
    en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = 1'b0; cfg_interval = '0;
    @(negedge clk_edge);
    @(negedge clk_edge);
    checkOutput("reset_led", 32'(led), 0);
    checkOutput("reset_any", 32'(any_pulse), 0);

    // Default intervals: ch0 every 10, ch1 every 5, coinciding at edge 10
    reset_dut();
    for (int k = 1; k <= 35; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      if (k == 5)  checkOutput("t1_ch1_edge5", 32'(led[1]), 1);
      if (k == 10) checkOutput("t1_coincide", 32'(led[1:0]), 32'h3);
      if (k == 10) checkOutput("t1_any_edge10", 32'(any_pulse), 1);
      if (k == 20) checkOutput("t1_ch0_edge20", 32'(led[0]), 1);
    end

    // Random channel: 200 pulses, every gap within [4,19]
    reset_dut();
    pulses = 0; gap = 0; cyc = 0;
    while (pulses < 200 && cyc < 6000) begin
      applyStimulus(1, 0, 0, 0, 0);
      cyc++; gap++;
      if (led[2]) begin
        if (pulses == 0) checkOutput("t2_first_pulse", 32'(gap), 5);
        else checkOutput("t2_gap_range", 32'(gap >= 4 && gap <= 19), 1);
        pulses++;
        gap = 0;
      end
    end
    checkOutput("t2_pulse_count", 32'(pulses), 200);

    // Reconfigure ch1 to interval 3 on edge 7
    reset_dut();
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1, k == 7, 2'd1, 0, 8'd3);
      if (k == 10) checkOutput("t3_edge10", 32'(led[1:0]), 32'h3);
      if (k == 13) checkOutput("t3_ch1_edge13", 32'(led[1]), 1);
      if (k == 16) checkOutput("t3_ch1_edge16", 32'(led[1]), 1);
    end

    // Disable ch0, then interval 1 keeps it high every cycle
    applyStimulus(1, 1, 2'd0, 0, 8'd0);
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      if (led[0]) pulses++;
    end
    checkOutput("t4_disabled_quiet", 32'(pulses), 0);
    applyStimulus(1, 1, 2'd0, 0, 8'd1);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      if (led[0]) pulses++;
    end
    checkOutput("t4_interval1_high", 32'(pulses), 20);

    // Enable low for edges 3..8: count resumes from held value
    reset_dut();
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(!(k >= 3 && k <= 8), 0, 0, 0, 0);
      if (k == 11) checkOutput("t5_ch1_edge11", 32'(led[1]), 1);
      if (k == 16) checkOutput("t5_ch1_edge16", 32'(led[1]), 1);
    end

    // Asynchronous reset while ch1 is pulsing
    reset_dut();
    for (int k = 1; k <= 5; k++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t6_ch1_high", 32'(led[1]), 1);
    rstbtn = 1'b1;
    #1;
    checkOutput("t6_async_drop", 32'(led), 0);
    reset_dut();
    for (int k = 1; k <= 30; k++) applyStimulus(1, 0, 0, 0, 0);

    // Random enables and configuration writes, including an invalid channel
    reset_dut();
    for (int k = 0; k < 3000; k++) begin
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 12)));
    end

    @(posedge clk_edge);
    #2;
    checkOutput("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
